netbus_rx_arbiter: RTL and testbench

//  N-port frame arbiter for the NetBus receive path, RCLK domain only; sits after N NetBusSliceRx CDC slices.

---
 rtl/netbus_pkg.sv | 23 ++
 rtl/netbus_rr_select.sv | 32 +++
 rtl/netbus_rx_arbiter.sv | 142 ++++++++++++++
 tb/tb_netbus_rx_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/netbus_pkg.sv
// Shared definitions for the NetBus receive-path arbiter.
//   nb_word_w()  : NetBus word width for a given lane width
//   NB_EOF_BIT   : bit position of the end-of-frame flag in each word
//   ARB_FIXED/RR : arbitration mode encodings
//   NB_WD_W      : watchdog counter width
//   arb_state_t  : arbiter FSM state encoding
package netbus_pkg;

   localparam int NB_EOF_BIT = 0;
   localparam int ARB_FIXED  = 0;
   localparam int ARB_RR     = 1;
   localparam int NB_WD_W    = 16;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   function automatic int nb_word_w(input int dw);
      return dw * 9 + 14;
   endfunction

endpackage

// File: rtl/netbus_rr_select.sv
// Combinational circular priority pick: returns the first set bit of req
// scanning upward from ptr and wrapping N-1 -> 0.
//   req : request vector (N bits)
//   ptr : starting index, must be < N
//   sel : index of the chosen request (0 when none)
//   any : at least one request set
module netbus_rr_select #(
   parameter int N  = 8,
   parameter int PB = 3
)(
   input  logic [N-1:0]  req,
   input  logic [PB-1:0] ptr,
   output logic [PB-1:0] sel,
   output logic          any
);

   always_comb begin
      int idx;
      sel = '0;
      any = 1'b0;
      idx = 0;
      for (int i = 0; i < N; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any = 1'b1;
            sel = PB'(idx);
         end
      end
   end

endmodule

// File: rtl/netbus_rx_arbiter.sv
// N-port frame arbiter for the NetBus receive path (RCLK domain).
// One port is granted at a time and held until its end-of-frame beat, so
// frames never interleave. Fixed-priority or round-robin, with per-port
// real-time eligibility and an optional stall watchdog.
//   RCLK, RESETn  : clock, async active-low reset
//   IN_DATA       : NUM_PORTS packed words, port i at [i*W +: W], bit 0 = EOF
//   IN_VALID      : per-port word valid
//   IN_FRAME      : per-port complete-frame-buffered flag
//   IN_READY      : per-port ready, one-hot at the granted port (or zero)
//   RDATA/RVALID  : granted port's word / valid, combinational pass-through
//   RREADY        : downstream ready
//   GRANT_ID      : current or last granted port
//   GRANT_ACTIVE  : a grant is held
//   ABORT         : one-cycle pulse when the watchdog drops a stalled grant
module netbus_rx_arbiter
   import netbus_pkg::*;
#(
   parameter int                   DATA_WIDTH      = 4,
   parameter int                   NUM_PORTS       = 8,
   parameter int                   ARB_MODE        = ARB_FIXED,
   parameter logic [NUM_PORTS-1:0] REAL_TIME_MASK  = '0,
   parameter int                   WATCHDOG_CYCLES = 0,
   localparam int                  W  = nb_word_w(DATA_WIDTH),
   localparam int                  PB = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
)(
   input  logic                   RCLK,
   input  logic                   RESETn,
   input  logic [NUM_PORTS*W-1:0] IN_DATA,
   input  logic [NUM_PORTS-1:0]   IN_VALID,
   input  logic [NUM_PORTS-1:0]   IN_FRAME,
   output logic [NUM_PORTS-1:0]   IN_READY,
   output logic [W-1:0]           RDATA,
   output logic                   RVALID,
   input  logic                   RREADY,
   output logic [PB-1:0]          GRANT_ID,
   output logic                   GRANT_ACTIVE,
   output logic                   ABORT
);

   arb_state_t                   state_q, state_d;
   logic [PB-1:0]                gid_q, gid_d;
   logic [PB-1:0]                ptr_q, ptr_d;
   logic [NB_WD_W-1:0]           wd_q, wd_d;
   logic                         abort_q, abort_d;

   logic [NUM_PORTS-1:0]         elig;
   logic [NUM_PORTS-1:0][W-1:0]  words;
   logic [PB-1:0]                g_next, sel_ptr, sel;
   logic                         any, granted, g_valid, hs, eof, wd_hit;

   // Per-port eligibility source: live valid for real-time ports, else a
   // fully buffered frame.
   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign elig[gi] = REAL_TIME_MASK[gi] ? IN_VALID[gi] : IN_FRAME[gi];
   end

   assign words   = IN_DATA;
   assign granted = (state_q == ARB_GRANT);
   assign g_valid = granted & IN_VALID[gid_q];
   assign hs      = g_valid & RREADY;
   assign eof     = hs & words[gid_q][NB_EOF_BIT];
   assign g_next  = (gid_q == PB'(NUM_PORTS - 1)) ? '0 : gid_q + PB'(1);

   // On the EOF beat the search already starts past the finishing port so a
   // back-to-back grant sees it as lowest priority.
   assign sel_ptr = (ARB_MODE == ARB_RR) ? (eof ? g_next : ptr_q) : '0;

   netbus_rr_select #(.N(NUM_PORTS), .PB(PB)) u_sel (
      .req (elig),
      .ptr (sel_ptr),
      .sel (sel),
      .any (any)
   );

   // Fires on the edge where the idle count on the granted port would reach
   // the limit. Never coincides with EOF since EOF needs a valid word.
   assign wd_hit = (WATCHDOG_CYCLES > 0) && granted && !IN_VALID[gid_q] &&
                   (int'(wd_q) + 1 == WATCHDOG_CYCLES);

   // Data path: pure muxing, so RVALID never depends on RREADY.
   assign RDATA        = granted ? words[gid_q] : '0;
   assign RVALID       = g_valid;
   assign GRANT_ID     = gid_q;
   assign GRANT_ACTIVE = granted;
   assign ABORT        = abort_q;

   always_comb begin
      IN_READY = '0;
      if (granted) IN_READY[gid_q] = RREADY;
   end

   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      abort_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            wd_d = '0;
            if (any) begin
               state_d = ARB_GRANT;
               gid_d   = sel;
            end
         end
         ARB_GRANT: begin
            if (hs)
               wd_d = '0;
            else if ((WATCHDOG_CYCLES > 0) && !IN_VALID[gid_q])
               wd_d = wd_q + NB_WD_W'(1);
            if (eof) begin
               ptr_d = g_next;
               if (any) gid_d   = sel;
               else     state_d = ARB_IDLE;
            end else if (wd_hit) begin
               abort_d = 1'b1;
               state_d = ARB_IDLE;
               ptr_d   = g_next;
               wd_d    = '0;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge RCLK or negedge RESETn) begin
      if (!RESETn) begin
         state_q <= ARB_IDLE;
         gid_q   <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         abort_q <= abort_d;
      end
   end

endmodule

// File: tb/tb_netbus_rx_arbiter.sv
// Directed bench for netbus_rx_arbiter. Three instances share the input
// stimulus: fixed priority, round robin, and fixed with a real-time mask
// plus a 10-cycle watchdog. Each step resets and checks one instance.
module tb_netbus_rx_arbiter;

   localparam int NP = 8;
   localparam int W  = 4 * 9 + 14;

   logic            RCLK = 1'b0;
   logic            RESETn;
   logic [NP*W-1:0] in_data;
   logic [NP-1:0]   in_valid, in_frame;
   logic            rready;

   logic [NP-1:0] fx_ready, rr_ready, mk_ready;
   logic [W-1:0]  fx_rdata, rr_rdata, mk_rdata;
   logic          fx_rvalid, rr_rvalid, mk_rvalid;
   logic [2:0]    fx_gid, rr_gid, mk_gid;
   logic          fx_gact, rr_gact, mk_gact;
   logic          fx_abort, rr_abort, mk_abort;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 RCLK = ~RCLK;

   netbus_rx_arbiter #(.DATA_WIDTH(4), .NUM_PORTS(NP), .ARB_MODE(0)) u_fx (
      .RCLK(RCLK), .RESETn(RESETn), .IN_DATA(in_data), .IN_VALID(in_valid),
      .IN_FRAME(in_frame), .IN_READY(fx_ready), .RDATA(fx_rdata),
      .RVALID(fx_rvalid), .RREADY(rready), .GRANT_ID(fx_gid),
      .GRANT_ACTIVE(fx_gact), .ABORT(fx_abort));

   netbus_rx_arbiter #(.DATA_WIDTH(4), .NUM_PORTS(NP), .ARB_MODE(1)) u_rr (
      .RCLK(RCLK), .RESETn(RESETn), .IN_DATA(in_data), .IN_VALID(in_valid),
      .IN_FRAME(in_frame), .IN_READY(rr_ready), .RDATA(rr_rdata),
      .RVALID(rr_rvalid), .RREADY(rready), .GRANT_ID(rr_gid),
      .GRANT_ACTIVE(rr_gact), .ABORT(rr_abort));

   netbus_rx_arbiter #(.DATA_WIDTH(4), .NUM_PORTS(NP), .ARB_MODE(0),
                       .REAL_TIME_MASK(8'h04), .WATCHDOG_CYCLES(10)) u_mk (
      .RCLK(RCLK), .RESETn(RESETn), .IN_DATA(in_data), .IN_VALID(in_valid),
      .IN_FRAME(in_frame), .IN_READY(mk_ready), .RDATA(mk_rdata),
      .RVALID(mk_rvalid), .RREADY(rready), .GRANT_ID(mk_gid),
      .GRANT_ACTIVE(mk_gact), .ABORT(mk_abort));

   function automatic logic [W-1:0] mk(input int p, input int k, input bit eof);
      logic [W-1:0] w;
      w        = '0;
      w[0]     = eof;
      w[8:1]   = 8'(k);
      w[16:9]  = 8'(p);
      w[24:17] = 8'hA5;
      return w;
   endfunction

   task automatic put(input int p, input int k, input bit eof);
      in_data[p*W +: W] = mk(p, k, eof);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the active edge; checks follow 1 unit later.
   task automatic tick();
      @(posedge RCLK);
      #2;
   endtask

   task automatic do_reset();
      RESETn   = 1'b0;
      in_data  = '0;
      in_valid = '0;
      in_frame = '0;
      rready   = 1'b0;
      repeat (2) @(posedge RCLK);
      #2 RESETn = 1'b1;
   endtask

   initial begin
      int k;
      bit hs;
      int order [4];
      order = '{0, 1, 3, 0};

      // ---- reset state
      do_reset();
      #1;
      chk("rst_rvalid", 64'(fx_rvalid), 64'd0);
      chk("rst_ready",  64'(fx_ready),  64'd0);
      chk("rst_gact",   64'(fx_gact),   64'd0);
      chk("rst_gid",    64'(fx_gid),    64'd0);
      chk("rst_abort",  64'(fx_abort),  64'd0);

      // ---- 1: fixed, single 4-word frame on port 2
      do_reset();
      in_frame[2] = 1'b1; in_valid[2] = 1'b1; put(2, 0, 0); rready = 1'b1;
      #1 chk("t1_idle_gact", 64'(fx_gact), 64'd0);
      chk("t1_idle_rvalid", 64'(fx_rvalid), 64'd0);
      tick();
      for (int b = 0; b < 4; b++) begin
         put(2, b, b == 3);
         if (b == 3) in_frame[2] = 1'b0;
         #1;
         chk("t1_gid",    64'(fx_gid),    64'd2);
         chk("t1_rvalid", 64'(fx_rvalid), 64'd1);
         chk("t1_rdata",  64'(fx_rdata),  64'(mk(2, b, b == 3)));
         chk("t1_ready",  64'(fx_ready),  64'h04);
         tick();
      end
      in_valid[2] = 1'b0;
      #1;
      chk("t1_end_gact",   64'(fx_gact),   64'd0);
      chk("t1_end_rvalid", 64'(fx_rvalid), 64'd0);
      chk("t1_end_ready",  64'(fx_ready),  64'd0);
      chk("t1_end_gid",    64'(fx_gid),    64'd2);

      // ---- 2: round robin over ports 0,1,3 with 2-word frames
      do_reset();
      in_frame = 8'b0000_1011; in_valid = 8'b0000_1011;
      put(0, 0, 0); put(1, 0, 0); put(3, 0, 0); rready = 1'b1;
      tick();
      for (int f = 0; f < 4; f++) begin
         for (int b = 0; b < 2; b++) begin
            put(order[f], b, b == 1);
            #1;
            chk("t2_gact",  64'(rr_gact),  64'd1);
            chk("t2_gid",   64'(rr_gid),   64'(order[f]));
            chk("t2_rdata", 64'(rr_rdata), 64'(mk(order[f], b, b == 1)));
            tick();
            if (b == 1) put(order[f], 0, 0);
         end
      end
      #1 chk("t2_next_gid", 64'(rr_gid), 64'd1);

      // ---- 3: fixed, port 0 refills and starves port 5
      do_reset();
      in_frame = 8'b0010_0001; in_valid = 8'b0010_0001;
      put(0, 0, 0); put(5, 0, 0); rready = 1'b1;
      tick();
      for (int f = 0; f < 2; f++) begin
         for (int b = 0; b < 2; b++) begin
            put(0, b, b == 1);
            #1;
            chk("t3_gid",   64'(fx_gid),   64'd0);
            chk("t3_ready", 64'(fx_ready), 64'h01);
            tick();
         end
      end
      put(0, 0, 0);
      #1;
      chk("t3_starve_gact", 64'(fx_gact), 64'd1);
      chk("t3_starve_gid",  64'(fx_gid),  64'd0);

      // ---- 4: real-time mask 8'h04
      do_reset();
      in_valid[3] = 1'b1; put(3, 0, 1); rready = 1'b1;
      tick();
      #1 chk("t4_p3_not_granted", 64'(mk_gact), 64'd0);
      in_valid[2] = 1'b1; put(2, 0, 0);
      tick();
      #1;
      chk("t4_p2_gact", 64'(mk_gact), 64'd1);
      chk("t4_p2_gid",  64'(mk_gid),  64'd2);
      put(2, 1, 1);
      tick();
      in_valid[2] = 1'b0;
      #1;
      chk("t4_regrant_gid",    64'(mk_gid),    64'd2);
      chk("t4_regrant_rvalid", 64'(mk_rvalid), 64'd0);

      // ---- 5: watchdog on a stalled port 1 frame
      do_reset();
      in_frame[1] = 1'b1; in_valid[1] = 1'b1; put(1, 0, 0);
      in_valid[2] = 1'b1; put(2, 0, 1); rready = 1'b1;
      tick();
      #1 chk("t5_gid", 64'(mk_gid), 64'd1);
      tick();
      put(1, 1, 0);
      tick();
      in_valid[1] = 1'b0; in_frame[1] = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         tick();
         #1;
         if (i < 10) begin
            chk("t5_wait_abort", 64'(mk_abort), 64'd0);
            chk("t5_wait_gact",  64'(mk_gact),  64'd1);
         end else begin
            chk("t5_abort",        64'(mk_abort),  64'd1);
            chk("t5_abort_gact",   64'(mk_gact),   64'd0);
            chk("t5_abort_rvalid", 64'(mk_rvalid), 64'd0);
         end
      end
      tick();
      #1;
      chk("t5_abort_pulse", 64'(mk_abort), 64'd0);
      chk("t5_next_gid",    64'(mk_gid),   64'd2);
      chk("t5_next_gact",   64'(mk_gact),  64'd1);

      // ---- 6: RREADY toggling mid-frame
      do_reset();
      in_frame[4] = 1'b1; in_valid[4] = 1'b1; put(4, 0, 0);
      tick();
      k = 0;
      for (int c = 0; c < 8 && k < 4; c++) begin
         rready = (c % 2 == 0);
         put(4, k, k == 3);
         in_frame[4] = !(k == 3 && rready);
         #1;
         chk("t6_ready",  64'(fx_ready),  rready ? 64'h10 : 64'h00);
         chk("t6_rvalid", 64'(fx_rvalid), 64'd1);
         chk("t6_rdata",  64'(fx_rdata),  64'(mk(4, k, k == 3)));
         hs = rready;
         tick();
         if (hs) k++;
      end
      in_valid[4] = 1'b0;
      #1 chk("t6_end_gact", 64'(fx_gact), 64'd0);

      // ---- 7: reset asserted mid-frame
      do_reset();
      in_frame[4] = 1'b1; in_valid[4] = 1'b1; put(4, 0, 0); rready = 1'b1;
      tick();
      put(4, 1, 0);
      #1 chk("t7_pre_gact", 64'(fx_gact), 64'd1);
      RESETn = 1'b0;
      #1;
      chk("t7_rvalid", 64'(fx_rvalid), 64'd0);
      chk("t7_ready",  64'(fx_ready),  64'd0);
      chk("t7_gact",   64'(fx_gact),   64'd0);
      chk("t7_gid",    64'(fx_gid),    64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
